// File: rtl/mbist_controller_if.sv
// Memory/decoder bus for the MBIST controller.
//   q          pattern select to the background decoder
//   data_t     background pattern returned by the decoder
//   mem_addr   memory address
//   mem_we     write strobe
//   mem_re     read strobe; mem_rdata is valid one cycle later
//   mem_wdata  write data
//   mem_rdata  read data
// master: the controller side. slave: the decoder and the memory side.
interface mbist_controller_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [2:0]            q;
  logic [DATA_WIDTH-1:0] data_t;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output q, mem_addr, mem_we, mem_re, mem_wdata,
    input  data_t, mem_rdata
  );

  modport slave (
    input  q, mem_addr, mem_we, mem_re, mem_wdata,
    output data_t, mem_rdata
  );
endinterface

// File: rtl/mbist_controller.sv
// MBIST sequencer. For each pattern q = 0..NUM_PATTERNS-1 it writes the decoder
// background to every address (ascending), reads every address back and compares
// against the decoder output. Reports done, a sticky fail flag and the address
// and pattern of the first mismatch.
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   start_i        start pulse, accepted only in idle or done
//   bus            decoder select/pattern and memory strobes (master side)
//   busy_o         test running
//   done_o         test finished, held until the next start
//   fail_o         sticky mismatch flag
//   fail_addr_o    address of the first mismatch
//   fail_q_o       pattern of the first mismatch
module mbist_controller #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_PATTERNS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  mbist_controller_if.master    bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_q_o
);

  localparam logic [2:0] LastQ = 3'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            q_q, q_d;
  logic                  rd_valid_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]            fail_pat_q, fail_pat_d;
  logic                  start_ok;
  logic                  mismatch;

  assign start_ok = start_i && (state_q == StIdle || state_q == StDone);
  // q has not advanced yet when the previous read is compared, so data_t is valid.
  assign mismatch = rd_valid_q && (bus.mem_rdata != bus.data_t);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    q_d     = q_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d = StWrite;
          addr_d  = '0;
          q_d     = '0;
        end
      end
      StWrite: begin
        addr_d = addr_q + 1'b1;  // wraps to 0 after the last address
        if (&addr_q) state_d = StRead;
      end
      StRead: begin
        addr_d = addr_q + 1'b1;
        if (&addr_q) state_d = StDrain;
      end
      StDrain: begin
        if (q_q == LastQ) begin
          state_d = StDone;
        end else begin
          q_d     = q_q + 3'd1;
          state_d = StWrite;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_pat_d  = fail_pat_q;
    if (start_ok) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_pat_d  = '0;
    end else if (mismatch && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = rd_addr_q;
      fail_pat_d  = q_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      q_q         <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_pat_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      q_q         <= q_d;
      rd_valid_q  <= (state_q == StRead);
      rd_addr_q   <= addr_q;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_pat_q  <= fail_pat_d;
    end
  end

  always_comb begin
    bus.q         = q_q;
    bus.mem_we    = (state_q == StWrite);
    bus.mem_re    = (state_q == StRead);
    bus.mem_addr  = (state_q == StWrite || state_q == StRead) ? addr_q : '0;
    bus.mem_wdata = bus.data_t;
    busy_o        = (state_q == StWrite || state_q == StRead || state_q == StDrain);
    done_o        = (state_q == StDone);
    fail_o        = fail_q;
    fail_addr_o   = fail_addr_q;
    fail_q_o      = fail_pat_q;
  end

endmodule

// File: tb/tb_mbist_controller.sv
module tb_mbist_controller;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NP = 6;
  localparam int D  = 16;
  localparam int DoneCyc = NP * (2 * D + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0] fail_q;

  always #5 clk = ~clk;

  mbist_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mbist_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PATTERNS(NP)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .bus         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_q_o    (fail_q)
  );

  // Background decoder model.
  function automatic logic [7:0] pat(input logic [2:0] p);
    case (p)
      3'd0: return 8'hAA;
      3'd1: return 8'h55;
      3'd2: return 8'hFF;
      3'd3: return 8'h00;
      3'd4: return 8'h0F;
      3'd5: return 8'hF0;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.data_t = pat(bus.q);

  // RAM with one optional stuck-at bit.
  logic [7:0] ram [D];
  logic       fault_en = 1'b0;
  logic [3:0] fault_addr = '0;
  logic [2:0] fault_bit = '0;
  logic       fault_val = 1'b0;

  function automatic logic [7:0] faulty(input logic [3:0] a, input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= faulty(bus.mem_addr, ram[bus.mem_addr]);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         start_cyc;
    logic       fail;
    logic [3:0] addr;
    logic [2:0] q;
  } res_t;

  res_t       res_q[$];
  logic [8:0] strobe_q[$];  // {we, re, q, addr}
  int n_checks = 0;
  int n_pass = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: invariants every cycle, strobes and results against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      check("we_re_exclusive", 32'(bus.mem_we && bus.mem_re), 0);
      check("q_range", 32'(bus.q <= 3'(NP - 1)), 1);
      check("wdata_eq_data_t", 32'(bus.mem_wdata), 32'(bus.data_t));
      if (bus.mem_we || bus.mem_re) begin
        if (strobe_q.size() == 0)
          check("unexpected_strobe", 32'({bus.mem_we, bus.mem_re, bus.q, bus.mem_addr}), 0);
        else
          check("strobe", 32'({bus.mem_we, bus.mem_re, bus.q, bus.mem_addr}),
                32'(strobe_q.pop_front()));
      end else begin
        check("addr_idle_zero", 32'(bus.mem_addr), 0);
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("done_cycle", 32'(cyc - r.start_cyc), DoneCyc);
          check("result_fail", 32'(fail), 32'(r.fail));
          check("result_fail_addr", 32'(fail_addr), 32'(r.addr));
          check("result_fail_q", 32'(fail_q), 32'(r.q));
        end
      end
      done_prev = done;
    end
  end

  // Reference: march order, stored word seen through the fault, first difference wins.
  task automatic push_expected();
    res_t r;
    r.start_cyc = cyc;
    r.fail = 1'b0;
    r.addr = '0;
    r.q = '0;
    for (int p = 0; p < NP; p++) begin
      for (int a = 0; a < D; a++) strobe_q.push_back({1'b1, 1'b0, 3'(p), 4'(a)});
      for (int a = 0; a < D; a++) begin
        strobe_q.push_back({1'b0, 1'b1, 3'(p), 4'(a)});
        if (!r.fail && faulty(4'(a), pat(3'(p))) != pat(3'(p))) begin
          r.fail = 1'b1;
          r.addr = 4'(a);
          r.q = 3'(p);
        end
      end
    end
    res_q.push_back(r);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_q"}, 32'(bus.q), 0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 0);
    check({tag, "_we"}, 32'(bus.mem_we), 0);
    check({tag, "_re"}, 32'(bus.mem_re), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_fail"}, 32'(fail), 0);
    check({tag, "_fail_addr"}, 32'(fail_addr), 0);
    check({tag, "_fail_q"}, 32'(fail_q), 0);
  endtask

  // Entered and left at posedge+1. rst_at > 0 aborts the run with reset in that cycle.
  task automatic run_test(input bit repulse, input int rst_at);
    int k;
    push_expected();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("post_start_busy", 32'(busy), 1);
    check("post_start_done", 32'(done), 0);
    check("post_start_fail", 32'(fail), 0);
    check("post_start_fail_addr", 32'(fail_addr), 0);
    check("post_start_fail_q", 32'(fail_q), 0);
    check("post_start_we", 32'(bus.mem_we), 1);
    k = 1;
    while (!done && k < DoneCyc + 20) begin
      if (rst_at != 0 && k == rst_at) begin
        #1;
        rst = 1'b1;
        #1;
        strobe_q.delete();
        res_q.delete();
        check_reset_values("midtest_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      start = repulse && (k == 10 || k == 100);
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    check("done_timeout", 32'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    fault_en = 1'b0;
    run_test(1'b0, 0);
    fault_en = 1'b1; fault_addr = 4'd5; fault_bit = 3'd0; fault_val = 1'b0;
    run_test(1'b0, 0);
    fault_en = 1'b1; fault_addr = 4'd15; fault_bit = 3'd7; fault_val = 1'b1;
    run_test(1'b0, 0);
    // Restart from done after a failing run, with start re-pulsed mid-test.
    fault_en = 1'b0;
    run_test(1'b1, 0);
    // Mid-test reset with a failure already flagged.
    fault_en = 1'b1; fault_addr = 4'd3; fault_bit = 3'd1; fault_val = 1'b0;
    run_test(1'b0, 40);
    fault_en = 1'b0;
    run_test(1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      fault_en   = ($urandom_range(0, 3) != 0);
      fault_addr = 4'($urandom_range(0, D - 1));
      fault_bit  = 3'($urandom_range(0, 7));
      fault_val  = 1'($urandom_range(0, 1));
      run_test(1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_strobes_drained", 32'(strobe_q.size()), 0);
    check("scoreboard_results_drained", 32'(res_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
